// File: rtl/udma_tx_chan_resp.sv
// uDMA TX channel responder: holds TX channel config/status, fetches L2 data
// on peripheral request and returns it through a small read-data FIFO.
module udma_tx_chan_resp #(
  parameter int L2_WIDTH_NOAL = 19,
  parameter int TRANS_SIZE    = 20,
  parameter int DATA_SIZE     = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_i,
  input  logic [L2_WIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]    cfg_size_i,
  input  logic [1:0]               cfg_datasize_i,
  input  logic                     cfg_continuous_i,
  input  logic                     cfg_en_i,
  input  logic                     cfg_clr_i,
  output logic                     cfg_en_o,
  output logic                     cfg_pending_o,
  output logic [L2_WIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]    cfg_bytes_left_o,
  input  logic                     data_tx_req_i,
  output logic                     data_tx_gnt_o,
  input  logic [1:0]               data_tx_datasize_i,
  output logic [DATA_SIZE-1:0]     data_tx_o,
  output logic                     data_tx_valid_o,
  input  logic                     data_tx_ready_i,
  output logic                     mem_req_o,
  output logic [L2_WIDTH_NOAL-1:0] mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic [DATA_SIZE-1:0]     mem_rdata_i,
  input  logic                     mem_rvalid_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic                     active_q, active_d;
  logic                     pend_q, pend_d;
  logic [L2_WIDTH_NOAL-1:0] curr_q, curr_d;
  logic [L2_WIDTH_NOAL-1:0] start_q, start_d;
  logic [L2_WIDTH_NOAL-1:0] sh_addr_q, sh_addr_d;
  logic [TRANS_SIZE-1:0]    left_q, left_d;
  logic [TRANS_SIZE-1:0]    size_q, size_d;
  logic [TRANS_SIZE-1:0]    sh_size_q, sh_size_d;
  logic [1:0]               ds_q, ds_d;
  logic [1:0]               sh_ds_q, sh_ds_d;
  logic                     cont_q, cont_d;
  logic                     sh_cont_q, sh_cont_d;
  logic [CW-1:0]            out_q, out_d;
  logic [CW-1:0]            drop_q, drop_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [AW-1:0]            wp_q, wp_d;
  logic [AW-1:0]            rp_q, rp_d;
  logic [AW-1:0]            tw_q, tw_d;
  logic [AW-1:0]            tr_q, tr_d;
  logic [DATA_SIZE-1:0]     fifo_q [FIFO_DEPTH];
  logic [1:0]               tag_q  [FIFO_DEPTH];

  logic [TRANS_SIZE-1:0] step;
  logic [DATA_SIZE-1:0]  mask;
  logic [DATA_SIZE-1:0]  wdata;
  logic credit, gnt, done;
  logic drop_hit, ret, push, pop;
  logic ld_cfg, ld_sh, cap;
  logic unused_ds;

  assign unused_ds = ^data_tx_datasize_i;

  always_comb begin
    step = TRANS_SIZE'(4);
    unique case (ds_q)
      2'd0:    step = TRANS_SIZE'(1);
      2'd1:    step = TRANS_SIZE'(2);
      default: step = TRANS_SIZE'(4);
    endcase
  end

  // dropped beats still occupy credit until they come back
  assign credit = (int'(out_q) + int'(drop_q) + int'(cnt_q)) < FIFO_DEPTH;
  assign mem_req_o = data_tx_req_i & active_q & (left_q != '0)
                   & credit & ~cfg_clr_i;
  assign gnt  = mem_req_o & mem_gnt_i;
  assign done = gnt & (left_q <= step);

  assign drop_hit = mem_rvalid_i & (drop_q != '0);
  assign ret      = mem_rvalid_i & ~drop_hit;
  assign push     = ret & ~cfg_clr_i;
  assign pop      = (cnt_q != '0) & data_tx_ready_i;

  always_comb begin
    mask = '1;
    unique case (tag_q[tr_q])
      2'd0:    mask = {{(DATA_SIZE-8){1'b0}}, 8'hFF};
      2'd1:    mask = {{(DATA_SIZE-16){1'b0}}, 16'hFFFF};
      default: mask = '1;
    endcase
    wdata = mem_rdata_i & mask;
  end

  always_comb begin
    out_d  = out_q + CW'(gnt) - CW'(ret);
    drop_d = drop_q - CW'(drop_hit);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    wp_d   = wp_q + AW'(push);
    rp_d   = rp_q + AW'(pop);
    tw_d   = tw_q + AW'(gnt);
    tr_d   = tr_q + AW'(mem_rvalid_i);
    if (cfg_clr_i) begin
      drop_d = drop_q - CW'(drop_hit) + out_q - CW'(ret);
      out_d  = '0;
      cnt_d  = '0;
      wp_d   = '0;
      rp_d   = '0;
    end
  end

  always_comb begin
    active_d  = active_q;
    pend_d    = pend_q;
    curr_d    = curr_q;
    start_d   = start_q;
    left_d    = left_q;
    size_d    = size_q;
    ds_d      = ds_q;
    cont_d    = cont_q;
    sh_addr_d = sh_addr_q;
    sh_size_d = sh_size_q;
    sh_ds_d   = sh_ds_q;
    sh_cont_d = sh_cont_q;
    ld_cfg    = 1'b0;
    ld_sh     = 1'b0;
    cap       = 1'b0;
    if (gnt) begin
      curr_d = curr_q + L2_WIDTH_NOAL'(step);
      left_d = done ? '0 : left_q - step;
    end
    if (cfg_clr_i) begin
      active_d = 1'b0;
      pend_d   = 1'b0;
      left_d   = '0;
    end else if (done) begin
      if (cont_q) begin
        curr_d = start_q;
        left_d = size_q;
        cap    = cfg_en_i;
      end else if (pend_q) begin
        ld_sh  = 1'b1;
        pend_d = 1'b0;
        cap    = cfg_en_i;
      end else if (cfg_en_i) begin
        ld_cfg = 1'b1;
      end else begin
        active_d = 1'b0;
      end
    end else if (cfg_en_i) begin
      if (!active_q) ld_cfg = cfg_size_i != '0;
      else           cap    = 1'b1;
    end
    if (ld_sh) begin
      active_d = sh_size_q != '0;
      curr_d   = sh_addr_q;
      start_d  = sh_addr_q;
      left_d   = sh_size_q;
      size_d   = sh_size_q;
      ds_d     = sh_ds_q;
      cont_d   = sh_cont_q;
    end
    if (ld_cfg) begin
      active_d = cfg_size_i != '0;
      curr_d   = cfg_startaddr_i;
      start_d  = cfg_startaddr_i;
      left_d   = cfg_size_i;
      size_d   = cfg_size_i;
      ds_d     = cfg_datasize_i;
      cont_d   = cfg_continuous_i;
    end
    if (cap) begin
      pend_d    = 1'b1;
      sh_addr_d = cfg_startaddr_i;
      sh_size_d = cfg_size_i;
      sh_ds_d   = cfg_datasize_i;
      sh_cont_d = cfg_continuous_i;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      active_q  <= 1'b0;
      pend_q    <= 1'b0;
      curr_q    <= '0;
      start_q   <= '0;
      left_q    <= '0;
      size_q    <= '0;
      ds_q      <= '0;
      cont_q    <= 1'b0;
      sh_addr_q <= '0;
      sh_size_q <= '0;
      sh_ds_q   <= '0;
      sh_cont_q <= 1'b0;
      out_q     <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      tw_q      <= '0;
      tr_q      <= '0;
    end else begin
      active_q  <= active_d;
      pend_q    <= pend_d;
      curr_q    <= curr_d;
      start_q   <= start_d;
      left_q    <= left_d;
      size_q    <= size_d;
      ds_q      <= ds_d;
      cont_q    <= cont_d;
      sh_addr_q <= sh_addr_d;
      sh_size_q <= sh_size_d;
      sh_ds_q   <= sh_ds_d;
      sh_cont_q <= sh_cont_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      tw_q      <= tw_d;
      tr_q      <= tr_d;
    end
  end

  // datasize tag travels with each request so the mask matches the grant
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      if (push) fifo_q[wp_q] <= wdata;
      if (gnt)  tag_q[tw_q]  <= ds_q;
    end
  end

  assign cfg_en_o         = active_q;
  assign cfg_pending_o    = pend_q;
  assign cfg_curr_addr_o  = curr_q;
  assign cfg_bytes_left_o = left_q;
  assign mem_addr_o       = curr_q;
  assign data_tx_gnt_o    = gnt;
  assign data_tx_valid_o  = cnt_q != '0;
  assign data_tx_o        = fifo_q[rp_q];

endmodule

// File: tb/tb_udma_tx_chan_resp.sv
// Directed bench for udma_tx_chan_resp with an in-order L2 read model.
module tb_udma_tx_chan_resp;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [18:0] cfg_startaddr_i;
  logic [19:0] cfg_size_i;
  logic [1:0]  cfg_datasize_i;
  logic        cfg_continuous_i, cfg_en_i, cfg_clr_i;
  logic        cfg_en_o, cfg_pending_o;
  logic [18:0] cfg_curr_addr_o;
  logic [19:0] cfg_bytes_left_o;
  logic        data_tx_req_i, data_tx_gnt_o;
  logic [1:0]  data_tx_datasize_i;
  logic [31:0] data_tx_o;
  logic        data_tx_valid_o, data_tx_ready_i;
  logic        mem_req_o;
  logic [18:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_rvalid_i = 1'b0;

  udma_tx_chan_resp dut (
    .sys_clk_i(clk), .rst_i(rst_i),
    .cfg_startaddr_i(cfg_startaddr_i), .cfg_size_i(cfg_size_i),
    .cfg_datasize_i(cfg_datasize_i), .cfg_continuous_i(cfg_continuous_i),
    .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i),
    .cfg_en_o(cfg_en_o), .cfg_pending_o(cfg_pending_o),
    .cfg_curr_addr_o(cfg_curr_addr_o), .cfg_bytes_left_o(cfg_bytes_left_o),
    .data_tx_req_i(data_tx_req_i), .data_tx_gnt_o(data_tx_gnt_o),
    .data_tx_datasize_i(data_tx_datasize_i), .data_tx_o(data_tx_o),
    .data_tx_valid_o(data_tx_valid_o), .data_tx_ready_i(data_tx_ready_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  rsp_t        mq[$];
  int          cyc = 0;
  int          lat = 1;
  logic        mem_fixed = 1'b0;
  int          gcnt = 0;
  logic [31:0] gq[$];
  logic [31:0] dq[$];
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;

  function automatic logic [31:0] rdat(input logic [18:0] a);
    return mem_fixed ? 32'hDEADBEEF : {8'hC0, 5'b0, a};
  endfunction

  function automatic logic [31:0] ga(input int i);
    return (gq.size() > i) ? gq[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] da(input int i);
    return (dq.size() > i) ? dq[i] : 32'hFFFF_FFFF;
  endfunction

  // L2 model: fixed latency, in-order responses
  always @(posedge clk) begin
    cyc++;
    if (rst_i) begin
      mq.delete();
      mem_rvalid_i <= 1'b0;
    end else begin
      if (mem_req_o && mem_gnt_i)
        mq.push_back('{due: cyc + lat - 1, d: rdat(mem_addr_o)});
      mem_rvalid_i <= 1'b0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mem_rvalid_i <= 1'b1;
        mem_rdata_i  <= mq[0].d;
        void'(mq.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_i) begin
      if (data_tx_gnt_o) begin
        gcnt++;
        gq.push_back(32'(mem_addr_o));
      end
      if (data_tx_valid_o && data_tx_ready_i) dq.push_back(data_tx_o);
      if (hold_v) chk("hold", {data_tx_valid_o, data_tx_o[30:0]},
                      {1'b1, hold_d[30:0]});
      hold_v = data_tx_valid_o & ~data_tx_ready_i & ~cfg_clr_i;
      hold_d = data_tx_o;
      chk("ovf", (dut.cnt_q > 3'd4) ? 32'd1 : 32'd0, 32'd0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [18:0] a, input logic [19:0] s,
                       input logic [1:0] d, input logic c);
    cfg_startaddr_i  = a;
    cfg_size_i       = s;
    cfg_datasize_i   = d;
    cfg_continuous_i = c;
    cfg_en_i         = 1'b1;
    @(negedge clk);
    cfg_en_i = 1'b0;
    #1;
  endtask

  task automatic clrq();
    gq.delete();
    dq.delete();
    gcnt = 0;
  endtask

  initial begin
    rst_i = 1'b1;
    cfg_startaddr_i = '0;
    cfg_size_i = '0;
    cfg_datasize_i = '0;
    cfg_continuous_i = 1'b0;
    cfg_en_i = 1'b0;
    cfg_clr_i = 1'b0;
    data_tx_req_i = 1'b0;
    data_tx_datasize_i = 2'd2;
    data_tx_ready_i = 1'b1;
    mem_gnt_i = 1'b1;
    repeat (3) step();
    chk("rst_en", 32'(cfg_en_o), 0);
    chk("rst_pend", 32'(cfg_pending_o), 0);
    chk("rst_addr", 32'(cfg_curr_addr_o), 0);
    chk("rst_left", 32'(cfg_bytes_left_o), 0);
    chk("rst_valid", 32'(data_tx_valid_o), 0);
    chk("rst_data", data_tx_o, 0);
    chk("rst_mreq", {mem_req_o, 12'(mem_addr_o)}, 0);
    rst_i = 1'b0;
    step();

    // word transfer
    clrq();
    start(19'h100, 20'd8, 2'd2, 1'b0);
    data_tx_req_i = 1'b1;
    #1;
    chk("w_en", 32'(cfg_en_o), 1);
    chk("w_left0", 32'(cfg_bytes_left_o), 8);
    chk("w_maddr0", {mem_req_o, 19'(mem_addr_o)}, {1'b1, 19'h100});
    chk("w_gnt0", 32'(data_tx_gnt_o), 1);
    step();
    chk("w_left1", 32'(cfg_bytes_left_o), 4);
    chk("w_addr1", 32'(cfg_curr_addr_o), 32'h104);
    step();
    chk("w_left2", 32'(cfg_bytes_left_o), 0);
    chk("w_en_off", 32'(cfg_en_o), 0);
    chk("w_gnt_off", 32'(data_tx_gnt_o), 0);
    data_tx_req_i = 1'b0;
    repeat (4) step();
    chk("w_gcnt", 32'(gcnt), 2);
    chk("w_ga0", ga(0), 32'h100);
    chk("w_ga1", ga(1), 32'h104);
    chk("w_dcnt", 32'(dq.size()), 2);
    chk("w_d0", da(0), 32'hC000_0100);
    chk("w_d1", da(1), 32'hC000_0104);

    // byte masking
    clrq();
    mem_fixed = 1'b1;
    start(19'h100, 20'd3, 2'd0, 1'b0);
    data_tx_req_i = 1'b1;
    #1;
    chk("b_addr0", 32'(cfg_curr_addr_o), 32'h100);
    step();
    chk("b_addr1", 32'(cfg_curr_addr_o), 32'h101);
    step();
    chk("b_addr2", 32'(cfg_curr_addr_o), 32'h102);
    step();
    chk("b_addr3", 32'(cfg_curr_addr_o), 32'h103);
    chk("b_en_off", {cfg_en_o, 20'(cfg_bytes_left_o)}, 0);
    data_tx_req_i = 1'b0;
    repeat (4) step();
    mem_fixed = 1'b0;
    chk("b_dcnt", 32'(dq.size()), 3);
    chk("b_d0", da(0), 32'h0000_00EF);
    chk("b_d2", da(2), 32'h0000_00EF);

    // backpressure
    clrq();
    data_tx_ready_i = 1'b0;
    start(19'h000, 20'd128, 2'd2, 1'b0);
    data_tx_req_i = 1'b1;
    repeat (10) step();
    chk("bp_gcnt4", 32'(gcnt), 4);
    chk("bp_nognt", {data_tx_gnt_o, mem_req_o}, 0);
    chk("bp_valid", 32'(data_tx_valid_o), 1);
    chk("bp_head0", data_tx_o, 32'hC000_0000);
    chk("bp_left", 32'(cfg_bytes_left_o), 112);
    data_tx_ready_i = 1'b1;
    step();
    data_tx_ready_i = 1'b0;
    repeat (10) step();
    chk("bp_gcnt5", 32'(gcnt), 5);
    chk("bp_dcnt", 32'(dq.size()), 1);
    chk("bp_head1", data_tx_o, 32'hC000_0004);
    cfg_clr_i = 1'b1;
    step();
    cfg_clr_i = 1'b0;
    data_tx_req_i = 1'b0;
    data_tx_ready_i = 1'b1;
    #1;
    chk("bp_clr", {cfg_en_o, data_tx_valid_o, 20'(cfg_bytes_left_o)}, 0);
    repeat (3) step();

    // pending
    clrq();
    start(19'h100, 20'd4, 2'd2, 1'b0);
    start(19'h200, 20'd4, 2'd2, 1'b0);
    chk("p_pend", {cfg_en_o, cfg_pending_o}, 2'b11);
    chk("p_addr0", 32'(cfg_curr_addr_o), 32'h100);
    data_tx_req_i = 1'b1;
    #1;
    chk("p_gnt0", 32'(data_tx_gnt_o), 1);
    step();
    chk("p_addr1", 32'(cfg_curr_addr_o), 32'h200);
    chk("p_state1", {cfg_en_o, cfg_pending_o, data_tx_gnt_o}, 3'b101);
    chk("p_left1", 32'(cfg_bytes_left_o), 4);
    step();
    chk("p_idle", 32'(cfg_en_o), 0);
    data_tx_req_i = 1'b0;
    repeat (3) step();
    chk("p_gcnt", 32'(gcnt), 2);
    chk("p_ga1", ga(1), 32'h200);

    // continuous
    clrq();
    start(19'h300, 20'd8, 2'd2, 1'b1);
    data_tx_req_i = 1'b1;
    step();
    chk("c_addr1", 32'(cfg_curr_addr_o), 32'h304);
    step();
    chk("c_reload", {cfg_en_o, 19'(cfg_curr_addr_o)}, {1'b1, 19'h300});
    chk("c_left", 32'(cfg_bytes_left_o), 8);
    data_tx_req_i = 1'b0;
    cfg_clr_i = 1'b1;
    step();
    cfg_clr_i = 1'b0;
    #1;
    chk("c_clr", {cfg_en_o, cfg_pending_o, data_tx_valid_o}, 0);
    repeat (3) step();

    // clear with beats in flight
    clrq();
    lat = 3;
    start(19'h400, 20'd16, 2'd2, 1'b0);
    data_tx_req_i = 1'b1;
    step();
    step();
    cfg_clr_i = 1'b1;
    #1;
    chk("k_nognt", {data_tx_gnt_o, mem_req_o}, 0);
    step();
    cfg_clr_i = 1'b0;
    data_tx_req_i = 1'b0;
    #1;
    chk("k_off", {cfg_en_o, data_tx_valid_o, 20'(cfg_bytes_left_o)}, 0);
    repeat (5) step();
    chk("k_drop", 32'(dq.size()), 0);
    chk("k_gcnt", 32'(gcnt), 2);
    lat = 1;
    start(19'h500, 20'd8, 2'd2, 1'b0);
    data_tx_req_i = 1'b1;
    repeat (3) step();
    data_tx_req_i = 1'b0;
    repeat (4) step();
    chk("k_gcnt2", 32'(gcnt), 4);
    chk("k_dcnt", 32'(dq.size()), 2);
    chk("k_d0", da(0), 32'hC000_0500);
    chk("k_d1", da(1), 32'hC000_0504);

    // odd size saturation
    clrq();
    start(19'h600, 20'd6, 2'd2, 1'b0);
    data_tx_req_i = 1'b1;
    #1;
    chk("o_left0", 32'(cfg_bytes_left_o), 6);
    step();
    chk("o_left1", {cfg_en_o, 20'(cfg_bytes_left_o)}, {1'b1, 20'd2});
    step();
    chk("o_left2", {cfg_en_o, 20'(cfg_bytes_left_o)}, 0);
    data_tx_req_i = 1'b0;
    repeat (3) step();
    chk("o_gcnt", 32'(gcnt), 2);

    // en with clr, and zero size
    cfg_startaddr_i = 19'h700;
    cfg_size_i = 20'd8;
    cfg_en_i = 1'b1;
    cfg_clr_i = 1'b1;
    step();
    cfg_en_i = 1'b0;
    cfg_clr_i = 1'b0;
    #1;
    chk("ec_idle", 32'(cfg_en_o), 0);
    start(19'h700, 20'd0, 2'd2, 1'b0);
    chk("z_idle", 32'(cfg_en_o), 0);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
